// File: rtl/op_nop_timed_if.sv
// Request/response bundle between the SPU sequencer and the timed NOP op unit.
// OP_NOP_TIMED_ABORT_EN adds the abort request and the aborted completion pulse.
interface op_nop_timed_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
);
   logic             start;
   logic             ready;
   logic [CNT_W-1:0] cycles;
   logic [1:0]       mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] n;
   logic             busy;
   logic             done;
`ifdef OP_NOP_TIMED_ABORT_EN
   logic             abort;
   logic             aborted;

   modport master (output start, cycles, mode, a, b, abort,
                   input  ready, m, n, busy, done, aborted);
   modport slave  (input  start, cycles, mode, a, b, abort,
                   output ready, m, n, busy, done, aborted);
`else
   modport master (output start, cycles, mode, a, b,
                   input  ready, m, n, busy, done);
   modport slave  (input  start, cycles, mode, a, b,
                   output ready, m, n, busy, done);
`endif
endinterface

// File: rtl/op_nop_timed.sv
// Timed NOP op: stalls K+1 cycles, then commits HOLD/CLEAR/SWAP/LOAD onto the M/N registers.
// Optional OP_NOP_TIMED_ABORT_EN: abort in WAIT returns to IDLE without committing.
module op_nop_timed #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   op_nop_timed_if.slave bus
);
   typedef enum logic {IDLE, WAIT} state_t;
   typedef enum logic [1:0] {MD_HOLD, MD_CLEAR, MD_SWAP, MD_LOAD} mode_t;

   typedef struct packed {
      mode_t            mode;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } req_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   req_t             req, req_nxt;
   logic [WIDTH-1:0] m_q, n_q, m_nxt, n_nxt;
   logic             busy_q, busy_nxt;
   logic             done_q, done_nxt;
   logic             abort_hit;
`ifdef OP_NOP_TIMED_ABORT_EN
   logic             aborted_q, aborted_nxt;

   assign abort_hit   = bus.abort;
   assign bus.aborted = aborted_q;
`else
   assign abort_hit   = 1'b0;
`endif

   assign bus.ready = (state == IDLE);
   assign bus.m     = m_q;
   assign bus.n     = n_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         req       <= '0;
         m_q       <= '0;
         n_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef OP_NOP_TIMED_ABORT_EN
         aborted_q <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         req       <= req_nxt;
         m_q       <= m_nxt;
         n_q       <= n_nxt;
         busy_q    <= busy_nxt;
         done_q    <= done_nxt;
`ifdef OP_NOP_TIMED_ABORT_EN
         aborted_q <= aborted_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      req_nxt     = req;
      m_nxt       = m_q;
      n_nxt       = n_q;
      busy_nxt    = busy_q;
      done_nxt    = 1'b0;
`ifdef OP_NOP_TIMED_ABORT_EN
      aborted_nxt = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = WAIT;
               cnt_nxt   = bus.cycles;
               req_nxt   = '{mode: mode_t'(bus.mode), a: bus.a, b: bus.b};
               busy_nxt  = 1'b1;
            end
         end
         WAIT: begin
            // abort outranks a coinciding commit: the mode is never applied
            if (abort_hit) begin
               state_nxt   = IDLE;
               busy_nxt    = 1'b0;
`ifdef OP_NOP_TIMED_ABORT_EN
               aborted_nxt = 1'b1;
`endif
            end else if (cnt != '0) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
               case (req.mode)
                  MD_CLEAR: begin
                     m_nxt = '0;
                     n_nxt = '0;
                  end
                  MD_SWAP: begin
                     m_nxt = n_q;
                     n_nxt = m_q;
                  end
                  MD_LOAD: begin
                     m_nxt = req.a;
                     n_nxt = req.b;
                  end
                  default: ;
               endcase
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule
